// File: rtl/axi_llc_split_unit_if.sv
// Descriptor types and the handshake bundle between the hit/miss detector,
// the split unit, and the bypass / miss pipelines downstream of it.
package axi_llc_split_unit_pkg;
  localparam int unsigned IdWidth   = 8;
  localparam int unsigned AddrWidth = 32;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [IdWidth-1:0]   a_x_id;
    logic                 rw;
    logic                 evict;
    logic                 refill;
    logic                 flush;
  } desc_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               rw;
    logic               valid;
  } cnt_t;
endpackage

interface axi_llc_split_unit_if;
  import axi_llc_split_unit_pkg::*;

  desc_t desc;
  logic  desc_valid;
  logic  desc_ready;
  desc_t bypass_desc;
  logic  bypass_valid;
  logic  bypass_ready;
  desc_t miss_desc;
  logic  miss_valid;
  logic  miss_ready;
  cnt_t  cnt_down;

  // split unit side
  modport slave (
    input  desc, desc_valid, bypass_ready, miss_ready, cnt_down,
    output desc_ready, bypass_desc, bypass_valid, miss_desc, miss_valid
  );

  // environment side: feeds descriptors, consumes both outputs
  modport master (
    output desc, desc_valid, bypass_ready, miss_ready, cnt_down,
    input  desc_ready, bypass_desc, bypass_valid, miss_desc, miss_valid
  );
endinterface

// File: rtl/axi_llc_split_unit.sv
// Routes hits to the bypass path and everything else to the miss pipeline.
// Per-(rw, id-index) counters track misses still inside the miss pipeline so a
// hit never overtakes an older miss with the same id and direction.
module axi_llc_split_unit
  import axi_llc_split_unit_pkg::*;
#(
  parameter int unsigned IdxBits  = 4,
  parameter int unsigned CntWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  axi_llc_split_unit_if.slave bus,
  output logic                idle_o,
  output logic                cnt_err_o
);

  localparam int unsigned NumIdx = 2 ** IdxBits;

  logic [1:0][NumIdx-1:0][CntWidth-1:0] cnt_q, cnt_d;
  logic                byp_valid_q, miss_valid_q;
  desc_t               byp_desc_q, miss_desc_q;
  logic                err_q;

  logic [IdxBits-1:0]  in_idx, dn_idx;
  logic [CntWidth-1:0] in_cnt;
  logic                is_hit, to_bypass, in_at_max;
  logic                byp_can, miss_can;
  logic                acc_byp, acc_miss, same_cnt, dec_zero;
  logic                cnt_id_unused;

  assign in_idx        = bus.desc.a_x_id[IdxBits-1:0];
  assign dn_idx        = bus.cnt_down.id[IdxBits-1:0];
  assign cnt_id_unused = ^bus.cnt_down.id;
  assign in_cnt        = cnt_q[bus.desc.rw][in_idx];
  assign is_hit        = !(bus.desc.evict | bus.desc.refill | bus.desc.flush);
  // Registered count only: a same-cycle decrement releases the hit one cycle later.
  assign to_bypass     = is_hit && (in_cnt == '0);
  assign in_at_max     = &in_cnt;
  assign byp_can       = !byp_valid_q || bus.bypass_ready;
  assign miss_can      = !miss_valid_q || bus.miss_ready;

  assign bus.desc_ready = !rst_i && bus.desc_valid &&
                          (to_bypass ? byp_can : (miss_can && !in_at_max));
  assign acc_byp  = bus.desc_ready && to_bypass;
  assign acc_miss = bus.desc_ready && !to_bypass;
  assign same_cnt = (bus.cnt_down.rw == bus.desc.rw) && (dn_idx == in_idx);

  // Next counter values: increment on miss acceptance, decrement on cnt_down.
  always_comb begin
    cnt_d    = cnt_q;
    dec_zero = 1'b0;
    if (acc_miss) begin
      cnt_d[bus.desc.rw][in_idx] = in_cnt + CntWidth'(1);
    end
    if (bus.cnt_down.valid) begin
      if (acc_miss && same_cnt) begin
        cnt_d[bus.cnt_down.rw][dn_idx] = cnt_q[bus.cnt_down.rw][dn_idx];
      end else if (cnt_q[bus.cnt_down.rw][dn_idx] == '0) begin
        dec_zero = 1'b1;
      end else begin
        cnt_d[bus.cnt_down.rw][dn_idx] = cnt_q[bus.cnt_down.rw][dn_idx] - CntWidth'(1);
      end
    end
  end

  // Counter state and sticky underflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (dec_zero) err_q <= 1'b1;
    end
  end

  // Bypass output register: load on acceptance, clear on handshake otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byp_valid_q <= 1'b0;
    end else if (byp_can) begin
      byp_valid_q <= acc_byp;
      if (acc_byp) byp_desc_q <= bus.desc;
    end
  end

  // Miss output register: same load/clear rule as the bypass register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_valid_q <= 1'b0;
    end else if (miss_can) begin
      miss_valid_q <= acc_miss;
      if (acc_miss) miss_desc_q <= bus.desc;
    end
  end

  assign bus.bypass_valid = byp_valid_q;
  assign bus.bypass_desc  = byp_desc_q;
  assign bus.miss_valid   = miss_valid_q;
  assign bus.miss_desc    = miss_desc_q;
  assign cnt_err_o        = err_q;
  assign idle_o           = (cnt_q == '0) && !byp_valid_q && !miss_valid_q;

endmodule

// File: tb/tb_axi_llc_split_unit.sv
// Directed bench for axi_llc_split_unit: a driver pushes expected descriptors
// into per-output queues, a monitor pops and compares on every handshake.
module tb_axi_llc_split_unit;
  import axi_llc_split_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic idle, cnt_err;

  axi_llc_split_unit_if bus();

  axi_llc_split_unit #(.IdxBits(4), .CntWidth(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus),
    .idle_o   (idle),
    .cnt_err_o(cnt_err)
  );

  always #5 clk = ~clk;

  desc_t       byp_q[$];
  desc_t       miss_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned tag   = 0;

  function automatic desc_t mk(input int id, input bit rw, input bit ev, input bit rf, input bit fl);
    desc_t d;
    tag      = tag + 1;
    d.addr   = 32'h8000_0000 + (tag << 6);
    d.a_x_id = 8'(id);
    d.rw     = rw;
    d.evict  = ev;
    d.refill = rf;
    d.flush  = fl;
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input desc_t d, input bit to_miss);
    bit done;
    done = 1'b0;
    bus.desc       = d;
    bus.desc_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.desc_ready) begin
        if (to_miss) miss_q.push_back(d);
        else         byp_q.push_back(d);
        done = 1'b1;
      end
      tick();
    end
    bus.desc_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: id %0d not accepted within 40 cycles", d.a_x_id);
    end
  endtask

  task automatic dec(input int id, input bit rw);
    bus.cnt_down = '{id: 8'(id), rw: rw, valid: 1'b1};
    tick();
    bus.cnt_down.valid = 1'b0;
  endtask

  // Monitor: compare every output handshake against the scoreboard heads.
  always @(negedge clk) begin
    desc_t e;
    if (bus.bypass_valid && bus.bypass_ready) begin
      n_vec++;
      if (byp_q.size() == 0) begin
        n_err++;
        $display("FAIL bypass_unexpected: got %0h expected nothing", bus.bypass_desc);
      end else begin
        e = byp_q.pop_front();
        if (bus.bypass_desc !== e) begin
          n_err++;
          $display("FAIL bypass_desc: got %0h expected %0h", bus.bypass_desc, e);
        end
      end
    end
    if (bus.miss_valid && bus.miss_ready) begin
      n_vec++;
      if (miss_q.size() == 0) begin
        n_err++;
        $display("FAIL miss_unexpected: got %0h expected nothing", bus.miss_desc);
      end else begin
        e = miss_q.pop_front();
        if (bus.miss_desc !== e) begin
          n_err++;
          $display("FAIL miss_desc: got %0h expected %0h", bus.miss_desc, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    desc_t d1, d9, dh;
    rst              = 1'b1;
    bus.desc         = mk(1, 0, 0, 0, 0);
    bus.desc_valid   = 1'b1;
    bus.bypass_ready = 1'b1;
    bus.miss_ready   = 1'b1;
    bus.cnt_down     = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ready",      bus.desc_ready,   0);
    chk("rst_idle",       idle,             1);
    chk("rst_byp_valid",  bus.bypass_valid, 0);
    chk("rst_miss_valid", bus.miss_valid,   0);
    chk("rst_err",        cnt_err,          0);
    tick();
    rst            = 1'b0;
    bus.desc_valid = 1'b0;
    tick();

    // plain hit to bypass, one-cycle latency, idle returns after handshake
    send(mk(3, 0, 0, 0, 0), 0);
    @(negedge clk);
    chk("hit_latency_valid", bus.bypass_valid, 1);
    chk("hit_busy_idle",     idle,             0);
    tick();
    @(negedge clk);
    chk("hit_idle_after", idle, 1);
    tick();

    // miss then same-id hit follows into miss; other direction bypasses
    send(mk(5, 1, 0, 1, 0), 1);
    send(mk(5, 1, 0, 0, 0), 1);
    send(mk(5, 0, 0, 0, 0), 0);
    tick();
    tick();
    @(negedge clk);
    chk("cnt15_two_idle", idle, 0);
    dec(5, 1);
    @(negedge clk);
    chk("cnt15_one_idle", idle, 0);
    tick();
    dec(5, 1);
    @(negedge clk);
    chk("cnt15_zero_idle", idle, 1);
    tick();

    // same-cycle decrement does not release the hit
    send(mk(2, 0, 1, 0, 0), 1);
    bus.desc       = mk(2, 0, 0, 0, 0);
    bus.desc_valid = 1'b1;
    bus.cnt_down   = '{id: 8'd2, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    chk("simul_ready", bus.desc_ready, 1);
    if (bus.desc_ready) miss_q.push_back(bus.desc);
    tick();
    bus.desc_valid     = 1'b0;
    bus.cnt_down.valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("simul_cnt_held", idle, 0);
    tick();
    dec(2, 0);
    send(mk(2, 0, 0, 0, 0), 0);
    tick();
    tick();
    @(negedge clk);
    chk("simul_drained_idle", idle,    1);
    chk("simul_no_err",       cnt_err, 0);
    tick();

    // saturate counter [0][7]; the 16th miss stalls until a decrement lands
    for (int i = 0; i < 15; i++) send(mk(7, 0, 0, 0, 1), 1);
    bus.desc       = mk(7, 0, 0, 0, 1);
    bus.desc_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("max_stall", bus.desc_ready, 0);
    tick();
    bus.cnt_down = '{id: 8'd7, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    chk("max_stall_same_cycle_dec", bus.desc_ready, 0);
    tick();
    bus.cnt_down.valid = 1'b0;
    @(negedge clk);
    chk("max_release", bus.desc_ready, 1);
    if (bus.desc_ready) miss_q.push_back(bus.desc);
    tick();
    bus.desc_valid = 1'b0;
    for (int i = 0; i < 15; i++) dec(7, 0);
    tick();
    @(negedge clk);
    chk("max_drained_idle", idle, 1);
    tick();

    // miss output blocked: bypass still flows, miss holds, next miss stalls
    bus.miss_ready = 1'b0;
    d1 = mk(1, 1, 0, 1, 0);
    send(d1, 1);
    dh = mk(4, 0, 0, 0, 0);
    send(dh, 0);
    d9 = mk(9, 0, 1, 0, 0);
    bus.desc       = d9;
    bus.desc_valid = 1'b1;
    @(negedge clk);
    chk("blk_stall",      bus.desc_ready, 0);
    chk("blk_miss_valid", bus.miss_valid, 1);
    chk("blk_miss_desc",  bus.miss_desc,  d1);
    tick();
    @(negedge clk);
    chk("blk_stall2",     bus.desc_ready, 0);
    chk("blk_miss_hold",  bus.miss_desc,  d1);
    tick();
    bus.miss_ready = 1'b1;
    @(negedge clk);
    chk("blk_release", bus.desc_ready, 1);
    if (bus.desc_ready) miss_q.push_back(d9);
    tick();
    bus.desc_valid = 1'b0;
    tick();
    tick();
    dec(1, 1);
    dec(9, 0);
    @(negedge clk);
    chk("blk_drained_idle", idle, 1);
    tick();

    // underflow is sticky; reset clears everything including in-flight state
    bus.miss_ready = 1'b0;
    send(mk(6, 1, 0, 1, 0), 1);
    dec(0, 1);
    @(negedge clk);
    chk("err_set",  cnt_err, 1);
    chk("err_busy", idle,    0);
    tick();
    tick();
    @(negedge clk);
    chk("err_sticky", cnt_err, 1);
    tick();
    rst            = 1'b1;
    bus.desc       = mk(8, 0, 0, 0, 0);
    bus.desc_valid = 1'b1;
    bus.cnt_down   = '{id: 8'd6, rw: 1'b1, valid: 1'b1};
    tick();
    @(negedge clk);
    chk("rst2_ready", bus.desc_ready, 0);
    tick();
    rst                = 1'b0;
    bus.desc_valid     = 1'b0;
    bus.cnt_down.valid = 1'b0;
    miss_q.delete();
    bus.miss_ready     = 1'b1;
    @(negedge clk);
    chk("rst2_err",        cnt_err,          0);
    chk("rst2_miss_valid", bus.miss_valid,   0);
    chk("rst2_byp_valid",  bus.bypass_valid, 0);
    chk("rst2_idle",       idle,             1);
    tick();

    repeat (3) tick();
    chk("byp_queue_empty",  byp_q.size(),  0);
    chk("miss_queue_empty", miss_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
